// File: rtl/board_io_pkg.sv
// Shared register map and seven-segment encoding for the board I/O controller.
// Pure definitions: no state, no latency, no flow control.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package board_io_pkg;

    localparam logic [1:0] ADDR_DISP  = 2'd0;
    localparam logic [1:0] ADDR_LEDDP = 2'd1;
    localparam logic [1:0] ADDR_SW    = 2'd2;
    localparam logic [1:0] ADDR_BTNEV = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/board_io_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE stable samples; rise is registered alongside stable.
// No backpressure: rise is a single-cycle pulse the consumer must capture.
module board_io_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          sample;

    assign sample = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (sample != stable) begin
                // The DEBOUNCE-th consecutive differing sample commits the change.
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    stable <= sample;
                    cnt    <= '0;
                    rise   <= sample;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Register-mapped board I/O: scanned 7-seg display, LED/dp register, switch sync, button events.
// Latency: register writes visible on led/seg/dp after one edge; sw reads 2 cycles; rd_data combinational.
// No backpressure; optional leading-zero blanking when BOARD_IO_LZB_EN is defined.
module board_io_ctrl #(
    parameter int DATA_W   = 16,
    parameter int N_DIGITS = 4,
    parameter int N_SW     = 8,
    parameter int N_BTN    = 4,
    parameter int N_LED    = 8,
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          addr,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [N_SW-1:0]     sw,
    input  logic [N_BTN-1:0]    btn,
    output logic [N_LED-1:0]    led,
    output logic [N_DIGITS-1:0] an,
    output logic                dp,
    output logic [6:0]          seg
);
    import board_io_pkg::*;

    localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DISP_W = 4 * N_DIGITS;
    localparam int LW     = N_LED + N_DIGITS;

    logic [DISP_W-1:0]   disp, disp_nxt;
    logic [LW-1:0]       leddp, leddp_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [DW-1:0]       dig, dig_nxt;
    logic [N_SW-1:0]     sw_s1, sw_s2;
    logic [N_BTN-1:0]    btnev, btnev_nxt, btn_rise, clr;
    logic [N_DIGITS-1:0] an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_btn
            board_io_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (btn[i]),
                .rise  (btn_rise[i])
            );
        end
    endgenerate

    // Display outputs are computed from next-state registers so a write shows up one edge later.
    always_comb begin
        disp_nxt = disp;
        if (wr_en && addr == ADDR_DISP) disp_nxt = wr_data[DISP_W-1:0];
        leddp_nxt = leddp;
        if (wr_en && addr == ADDR_LEDDP) leddp_nxt = wr_data[LW-1:0];

        cnt_nxt = cnt + 1'b1;
        dig_nxt = dig;
        if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt_nxt = '0;
            dig_nxt = (dig == DW'(N_DIGITS - 1)) ? '0 : dig + 1'b1;
        end

        an_nxt          = '1;
        an_nxt[dig_nxt] = 1'b0;
        seg_nxt         = seg_decode(disp_nxt[4*int'(dig_nxt) +: 4]);
`ifdef BOARD_IO_LZB_EN
        if (dig_nxt != '0 && (disp_nxt >> (4 * int'(dig_nxt))) == '0) seg_nxt = SEG_BLANK;
`endif
        dp_nxt = ~leddp_nxt[N_LED + int'(dig_nxt)];

        // A press landing on the clearing cycle survives.
        clr = '0;
        if (rd_en && addr == ADDR_BTNEV) clr = '1;
        if (wr_en && addr == ADDR_BTNEV) clr = clr | wr_data[N_BTN-1:0];
        btnev_nxt = (btnev & ~clr) | btn_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp  <= '0;
            leddp <= '0;
            cnt   <= '0;
            dig   <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            btnev <= '0;
            led   <= '0;
            an    <= '1;
            dp    <= 1'b1;
            seg   <= SEG_BLANK;
        end else begin
            disp  <= disp_nxt;
            leddp <= leddp_nxt;
            cnt   <= cnt_nxt;
            dig   <= dig_nxt;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            btnev <= btnev_nxt;
            led   <= leddp_nxt[N_LED-1:0];
            an    <= an_nxt;
            dp    <= dp_nxt;
            seg   <= seg_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DISP:  rd_data[DISP_W-1:0] = disp;
            ADDR_LEDDP: rd_data[LW-1:0]     = leddp;
            ADDR_SW:    rd_data[N_SW-1:0]   = sw_s2;
            default:    rd_data[N_BTN-1:0]  = btnev;
        endcase
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with SCAN_DIV=4, DEBOUNCE=3.
module tb_board_io_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic [7:0]  led;
    logic [3:0]  an;
    logic        dp;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    board_io_ctrl #(
        .DATA_W(16), .N_DIGITS(4), .N_SW(8), .N_BTN(4), .N_LED(8),
        .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .sw(sw), .btn(btn), .led(led),
        .an(an), .dp(dp), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an == target) found = 1;
        end
        check("an_wait", 32'(found), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        do_wr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    vec_t  vecs[7];
    slot_t scan[5];
    slot_t lzb[4];
    int    lat;

    initial begin
        vecs[0] = '{2'd0, 1'b1, 16'h12AF, 16'h12AF, 8'h00};
        vecs[1] = '{2'd1, 1'b1, 16'h05A5, 16'h05A5, 8'hA5};
        vecs[2] = '{2'd1, 1'b1, 16'hFFFF, 16'h0FFF, 8'hFF};
        vecs[3] = '{2'd2, 1'b1, 16'h1234, 16'h003C, 8'hFF};
        vecs[4] = '{2'd0, 1'b1, 16'h0000, 16'h0000, 8'hFF};
        vecs[5] = '{2'd1, 1'b1, 16'h0000, 16'h0000, 8'h00};
        vecs[6] = '{2'd3, 1'b0, 16'h0000, 16'h0000, 8'h00};

        // DISP=12AF, LEDDP=05A5: dp enabled on digits 0 and 2
        scan[0] = '{4'b1101, 7'h08, 1'b1};
        scan[1] = '{4'b1011, 7'h24, 1'b0};
        scan[2] = '{4'b0111, 7'h79, 1'b1};
        scan[3] = '{4'b1110, 7'h0E, 1'b0};
        scan[4] = '{4'b1101, 7'h08, 1'b1};

`ifdef BOARD_IO_LZB_EN
        lzb[0] = '{4'b1101, 7'h30, 1'b1};
        lzb[1] = '{4'b1011, 7'h7F, 1'b1};
        lzb[2] = '{4'b0111, 7'h7F, 1'b1};
        lzb[3] = '{4'b1110, 7'h40, 1'b1};
`else
        lzb[0] = '{4'b1101, 7'h30, 1'b1};
        lzb[1] = '{4'b1011, 7'h40, 1'b1};
        lzb[2] = '{4'b0111, 7'h40, 1'b1};
        lzb[3] = '{4'b1110, 7'h40, 1'b1};
`endif

        rst_n = 1'b0; addr = 2'd0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        sw = 8'h3C; btn = 4'b0000;

        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'h00);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'hF);
        check("rst_dp",  32'(dp),  32'h1);
        check("rst_disp", 32'(rd_data), 32'h0);
        addr = 2'd3;
        #1 check("rst_btnev", 32'(rd_data), 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("rel_an",  32'(an),  32'hE);
        check("rel_seg", 32'(seg), 32'h40);
        check("rel_led", 32'(led), 32'h00);

        // Register write / read-back table
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            addr = vecs[v].addr; wr_en = vecs[v].do_wr; wr_data = vecs[v].wdata;
            @(negedge clk);
            wr_en = 1'b0;
            check($sformatf("vec%0d_rd", v), 32'(rd_data), 32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
        end

        // Scan sequence including wrap to digit 0 and back
        reg_write(2'd0, 16'h12AF);
        reg_write(2'd1, 16'h05A5);
        check("scan_led", 32'(led), 32'hA5);
        wait_an(4'b1101);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan%0d_an", s),  32'(an),  32'(scan[s].an));
                check($sformatf("scan%0d_seg", s), 32'(seg), 32'(scan[s].seg));
                check($sformatf("scan%0d_dp", s),  32'(dp),  32'(scan[s].dp));
                @(negedge clk);
            end
        end

        // Leading-zero handling
        reg_write(2'd1, 16'h0000);
        reg_write(2'd0, 16'h0030);
        wait_an(4'b1101);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("lzb%0d_an", s),  32'(an),  32'(lzb[s].an));
                check($sformatf("lzb%0d_seg", s), 32'(seg), 32'(lzb[s].seg));
                @(negedge clk);
            end
        end

        // Short glitch rejected, held press latched, read clears, release ignored
        addr = 2'd3;
        @(negedge clk); btn[2] = 1'b1;
        repeat (2) @(negedge clk);
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_btnev", 32'(rd_data), 32'h0);
        btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("press_btnev", 32'(rd_data), 32'h4);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("rdclr_btnev", 32'(rd_data), 32'h0);
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("release_btnev", 32'(rd_data), 32'h0);

        // Measure press-to-event latency on btn[0]
        lat = 0;
        btn[0] = 1'b1;
        for (int k = 1; k <= 50 && lat == 0; k++) begin
            @(negedge clk);
            if (rd_data[0]) lat = k;
        end
        check("lat_found", 32'(lat != 0), 32'd1);
        check("lat_btnev", 32'(rd_data), 32'h1);

        // Press btn[1] so its event lands on the same edge as the read
        if (lat > 0) begin
            btn[1] = 1'b1;
            repeat (lat - 1) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            check("evt_wins_rd", 32'(rd_data), 32'h2);
        end

        // Write-1-to-clear
        reg_write(2'd3, 16'h0002);
        check("wr_clr", 32'(rd_data), 32'h0);

        // Asynchronous reset mid-operation
        reg_write(2'd0, 16'h12AF);
        reg_write(2'd1, 16'h05A5);
        addr = 2'd1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led",   32'(led), 32'h00);
        check("arst_seg",   32'(seg), 32'h7F);
        check("arst_an",    32'(an),  32'hF);
        check("arst_dp",    32'(dp),  32'h1);
        check("arst_leddp", 32'(rd_data), 32'h0);
        addr = 2'd0;
        #1 check("arst_disp", 32'(rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerel_an", 32'(an), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
